// File: rtl/sprite_command_pkg.sv
// Shared definitions for the sprite command unit: function codes used by the
// processor decode stage, the command FSM state type and the sprite slot layout.
package sprite_command_pkg;

   localparam logic [4:0] FUNCTION_SPRITE_LEVEL = 5'b00001;
   localparam logic [4:0] FUNCTION_SPRITE_POS   = 5'b00010;
   localparam logic [4:0] FUNCTION_WAIT_VSYNC   = 5'b00110;

   localparam int DEFAULT_COORD_WIDTH     = 10;
   localparam int DEFAULT_SPRITE_ID_WIDTH = 5;

   typedef enum logic {
      ACCEPT = 1'b0,
      WAIT   = 1'b1
   } state_t;

   // Slot layout at the processor's standard widths; the unit rebuilds the same
   // field order with its own parameter widths.
   typedef struct packed {
      logic [DEFAULT_COORD_WIDTH-1:0]     x;
      logic [DEFAULT_COORD_WIDTH-1:0]     y;
      logic [DEFAULT_SPRITE_ID_WIDTH-1:0] id;
      logic                               enable;
   } sprite_slot_t;

endpackage

// File: rtl/sprite_command_unit_slot_buffer.sv
// One double-buffered register: writes land in the shadow copy, which is
// copied to the active copy when commit is asserted.
module sprite_slot_buffer #(
   parameter int WIDTH = 26
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             write_enable,
   input  logic [WIDTH-1:0] write_data,
   input  logic             commit,
   output logic [WIDTH-1:0] active_data
);

   logic [WIDTH-1:0] shadow_data;

   // Commit uses the shadow value from before this edge, so a same-edge write
   // only becomes active on the following commit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow_data <= '0;
         active_data <= '0;
      end else begin
         if (write_enable) shadow_data <= write_data;
         if (commit)       active_data <= shadow_data;
      end
   end

endmodule

// File: rtl/sprite_command_unit.sv
// Sprite/background command unit: decodes graphics functions into double-buffered
// slot state, commits on vsync, and serves the renderer through a registered read port.
module sprite_command_unit
   import sprite_command_pkg::*;
#(
   parameter int NUM_SPRITES       = 32,
   parameter int COORD_WIDTH       = 10,
   parameter int SPRITE_ID_WIDTH   = 5,
   parameter int SLOT_WIDTH        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
   parameter int FRAME_COUNT_WIDTH = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [4:0]                   cmd_function,
   input  logic [SLOT_WIDTH-1:0]        cmd_slot,
   input  logic [COORD_WIDTH-1:0]       cmd_x,
   input  logic [COORD_WIDTH-1:0]       cmd_y,
   input  logic [SPRITE_ID_WIDTH-1:0]   cmd_sprite_id,
   input  logic                         vsync_pulse,
   input  logic [SLOT_WIDTH-1:0]        rd_slot,
   output logic [COORD_WIDTH-1:0]       rd_x,
   output logic [COORD_WIDTH-1:0]       rd_y,
   output logic [SPRITE_ID_WIDTH-1:0]   rd_sprite_id,
   output logic                         rd_enable,
   output logic [COORD_WIDTH-1:0]       background_x,
   output logic [COORD_WIDTH-1:0]       background_y,
   output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
   output logic                         cmd_error
);

   typedef struct packed {
      logic [COORD_WIDTH-1:0]     x;
      logic [COORD_WIDTH-1:0]     y;
      logic [SPRITE_ID_WIDTH-1:0] id;
      logic                       enable;
   } slot_entry_t;

   localparam int ENTRY_WIDTH = $bits(slot_entry_t);

   state_t                   state;
   state_t                   next_state;
   logic                     accept;
   logic                     cmd_slot_ok;
   logic                     rd_slot_ok;
   logic                     pos_write;
   logic                     level_write;
   logic                     error_next;
   logic [NUM_SPRITES-1:0]   slot_write;
   slot_entry_t              write_entry;
   slot_entry_t              read_entry;
   slot_entry_t              rd_entry;
   logic [ENTRY_WIDTH-1:0]   active_entries [NUM_SPRITES];
   logic [COORD_WIDTH-1:0]   shadow_background_x;
   logic [COORD_WIDTH-1:0]   shadow_background_y;

   assign cmd_ready = (state == ACCEPT);
   assign accept    = cmd_valid && cmd_ready;

   // Slot indices can only be out of range when the depth is not a power of two.
   generate
      if (NUM_SPRITES == (1 << SLOT_WIDTH)) begin : g_full_depth
         assign cmd_slot_ok = 1'b1;
         assign rd_slot_ok  = 1'b1;
      end else begin : g_partial_depth
         assign cmd_slot_ok = (cmd_slot < SLOT_WIDTH'(NUM_SPRITES));
         assign rd_slot_ok  = (rd_slot < SLOT_WIDTH'(NUM_SPRITES));
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ACCEPT;
      else        state <= next_state;
   end

   // WAIT is left only on a pulse seen while already waiting, so a pulse in the
   // accepting cycle cannot release it.
   always_comb begin
      next_state = state;
      case (state)
         ACCEPT:  if (accept && cmd_function == FUNCTION_WAIT_VSYNC) next_state = WAIT;
         WAIT:    if (vsync_pulse) next_state = ACCEPT;
         default: next_state = ACCEPT;
      endcase
   end

   always_comb begin
      pos_write   = 1'b0;
      level_write = 1'b0;
      error_next  = 1'b0;
      if (accept) begin
         case (cmd_function)
            FUNCTION_SPRITE_POS: begin
               if (cmd_slot_ok) pos_write  = 1'b1;
               else             error_next = 1'b1;
            end
            FUNCTION_SPRITE_LEVEL: level_write = 1'b1;
            FUNCTION_WAIT_VSYNC:   error_next  = 1'b0;
            default:               error_next  = 1'b1;
         endcase
      end
   end

   always_comb begin
      slot_write = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         slot_write[i] = pos_write && (cmd_slot == SLOT_WIDTH'(i));
      end
   end

   assign write_entry = '{x: cmd_x, y: cmd_y, id: cmd_sprite_id, enable: 1'b1};

   generate
      for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
         sprite_slot_buffer #(
            .WIDTH(ENTRY_WIDTH)
         ) u_slot (
            .clock       (clock),
            .reset       (reset),
            .write_enable(slot_write[g]),
            .write_data  (write_entry),
            .commit      (vsync_pulse),
            .active_data (active_entries[g])
         );
      end
   endgenerate

   always_comb begin
      read_entry = '0;
      if (rd_slot_ok) read_entry = slot_entry_t'(active_entries[rd_slot]);
   end

   // Background pair, frame counter, error pulse and the registered read port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow_background_x <= '0;
         shadow_background_y <= '0;
         background_x        <= '0;
         background_y        <= '0;
         frame_count         <= '0;
         cmd_error           <= 1'b0;
         rd_entry            <= '0;
      end else begin
         if (level_write) begin
            shadow_background_x <= cmd_x;
            shadow_background_y <= cmd_y;
         end
         if (vsync_pulse) begin
            background_x <= shadow_background_x;
            background_y <= shadow_background_y;
            frame_count  <= frame_count + 1'b1;
         end
         cmd_error <= error_next;
         rd_entry  <= read_entry;
      end
   end

   assign rd_x         = rd_entry.x;
   assign rd_y         = rd_entry.y;
   assign rd_sprite_id = rd_entry.id;
   assign rd_enable    = rd_entry.enable;

endmodule

// File: tb/tb_sprite_command_unit.sv
// Self-checking bench for sprite_command_unit: directed frame/commit scenarios
// plus randomized commands compared every cycle against a behavioural model.
module tb_sprite_command_unit;
   import sprite_command_pkg::*;

   localparam int NUM = 24;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [4:0] cmd_function = '0;
   logic [4:0] cmd_slot = '0;
   logic [9:0] cmd_x = '0;
   logic [9:0] cmd_y = '0;
   logic [4:0] cmd_sprite_id = '0;
   logic       vsync_pulse = 1'b0;
   logic [4:0] rd_slot = '0;
   logic [9:0] rd_x;
   logic [9:0] rd_y;
   logic [4:0] rd_sprite_id;
   logic       rd_enable;
   logic [9:0] background_x;
   logic [9:0] background_y;
   logic [15:0] frame_count;
   logic       cmd_error;

   int checks = 0;
   int failures = 0;

   sprite_command_unit #(
      .NUM_SPRITES(NUM)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_function (cmd_function),
      .cmd_slot     (cmd_slot),
      .cmd_x        (cmd_x),
      .cmd_y        (cmd_y),
      .cmd_sprite_id(cmd_sprite_id),
      .vsync_pulse  (vsync_pulse),
      .rd_slot      (rd_slot),
      .rd_x         (rd_x),
      .rd_y         (rd_y),
      .rd_sprite_id (rd_sprite_id),
      .rd_enable    (rd_enable),
      .background_x (background_x),
      .background_y (background_y),
      .frame_count  (frame_count),
      .cmd_error    (cmd_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      int x;
      int y;
      int id;
      int en;
   } entry_t;

   entry_t m_shadow [32];
   entry_t m_active [32];
   entry_t m_rd;
   int     m_bg_sx, m_bg_sy, m_bg_ax, m_bg_ay, m_frame;
   bit     m_waiting, m_error, m_accepted;
   bit     model_live = 1'b0;

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_stimulus(input bit valid, input logic [4:0] fn, input logic [4:0] slot,
                                 input logic [9:0] x, input logic [9:0] y, input logic [4:0] id,
                                 input bit vs, input logic [4:0] rds);
      @(posedge clock);
      #1;
      cmd_valid     = valid;
      cmd_function  = fn;
      cmd_slot      = slot;
      cmd_x         = x;
      cmd_y         = y;
      cmd_sprite_id = id;
      vsync_pulse   = vs;
      rd_slot       = rds;
   endtask

   task automatic idle(input logic [4:0] rds);
      apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b0, rds);
   endtask

   // Model: frame-level rules (reads see pre-commit state, commits copy the old
   // shadow, accepted commands only while not waiting for a frame boundary).
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            m_shadow[i] = '{0, 0, 0, 0};
            m_active[i] = '{0, 0, 0, 0};
         end
         m_rd = '{0, 0, 0, 0};
         m_bg_sx = 0; m_bg_sy = 0; m_bg_ax = 0; m_bg_ay = 0; m_frame = 0;
         m_waiting = 1'b0;
         m_error = 1'b0;
      end else begin
         m_accepted = cmd_valid && !m_waiting;
         if (int'(rd_slot) < NUM) m_rd = m_active[rd_slot];
         else                     m_rd = '{0, 0, 0, 0};
         m_error = 1'b0;
         if (vsync_pulse) begin
            m_active = m_shadow;
            m_bg_ax  = m_bg_sx;
            m_bg_ay  = m_bg_sy;
            m_frame  = (m_frame + 1) % 65536;
         end
         if (m_accepted) begin
            if (cmd_function == 5'b00010) begin
               if (int'(cmd_slot) < NUM) m_shadow[cmd_slot] = '{int'(cmd_x), int'(cmd_y), int'(cmd_sprite_id), 1};
               else                      m_error = 1'b1;
            end else if (cmd_function == 5'b00001) begin
               m_bg_sx = int'(cmd_x);
               m_bg_sy = int'(cmd_y);
            end else if (cmd_function != 5'b00110) begin
               m_error = 1'b1;
            end
         end
         if (m_waiting && vsync_pulse)                        m_waiting = 1'b0;
         else if (m_accepted && cmd_function == 5'b00110)     m_waiting = 1'b1;
      end
   end

   always @(negedge clock) begin
      if (reset && model_live) begin
         check_output("ready", cmd_ready, !m_waiting);
         check_output("error", cmd_error, m_error);
         check_output("rd_x", rd_x, m_rd.x);
         check_output("rd_y", rd_y, m_rd.y);
         check_output("rd_id", rd_sprite_id, m_rd.id);
         check_output("rd_en", rd_enable, m_rd.en);
         check_output("bg_x", background_x, m_bg_ax);
         check_output("bg_y", background_y, m_bg_ay);
         check_output("frame", frame_count, m_frame);
      end
   end

   initial begin
      $display("[TB] start");
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      model_live = 1'b1;

      // First frame after reset: everything zero, frame counter at one.
      apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd5);
      idle(5'd5);
      @(negedge clock);
      check_output("lit_frame1", frame_count, 1);
      check_output("lit_bg_x0", background_x, 0);
      check_output("lit_rd_en0", rd_enable, 0);

      // Sprite position only visible after the next commit.
      apply_stimulus(1'b1, FUNCTION_SPRITE_POS, 5'd3, 10'd100, 10'd50, 5'd7, 1'b0, 5'd3);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_pre_x", rd_x, 0);
      check_output("lit_pre_en", rd_enable, 0);
      apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd3);
      idle(5'd3);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_post_x", rd_x, 100);
      check_output("lit_post_y", rd_y, 50);
      check_output("lit_post_id", rd_sprite_id, 7);
      check_output("lit_post_en", rd_enable, 1);

      // Background write on a commit edge waits for the following frame.
      apply_stimulus(1'b1, FUNCTION_SPRITE_LEVEL, 5'd0, 10'd640, 10'd12, 5'd0, 1'b1, 5'd3);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_bg_hold_x", background_x, 0);
      check_output("lit_bg_hold_y", background_y, 0);
      apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd3);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_bg_x", background_x, 640);
      check_output("lit_bg_y", background_y, 12);

      // Wait accepted alongside a pulse; only the next pulse releases it.
      apply_stimulus(1'b1, FUNCTION_WAIT_VSYNC, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd3);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_wait_lo", cmd_ready, 0);
      repeat (19) idle(5'd3);
      apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd3);
      @(negedge clock);
      check_output("lit_wait_still", cmd_ready, 0);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_wait_rel", cmd_ready, 1);

      // Unsupported code and out-of-range slot each raise a single-cycle error.
      apply_stimulus(1'b1, 5'b00101, 5'd0, 10'd0, 10'd0, 5'd0, 1'b0, 5'd3);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_err_code", cmd_error, 1);
      idle(5'd3);
      @(negedge clock);
      check_output("lit_err_code_end", cmd_error, 0);
      apply_stimulus(1'b1, FUNCTION_SPRITE_POS, 5'd30, 10'd1, 10'd2, 5'd3, 1'b0, 5'd30);
      idle(5'd30);
      @(negedge clock);
      check_output("lit_err_slot", cmd_error, 1);
      idle(5'd30);
      @(negedge clock);
      check_output("lit_err_slot_end", cmd_error, 0);
      apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd30);
      idle(5'd30);
      idle(5'd30);
      @(negedge clock);
      check_output("lit_slot30_en", rd_enable, 0);
      check_output("lit_slot30_x", rd_x, 0);

      // Randomized command stream checked by the model.
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] fn;
         int pick;
         pick = $urandom_range(0, 9);
         if (pick <= 3 || pick == 9) fn = FUNCTION_SPRITE_POS;
         else if (pick <= 5)         fn = FUNCTION_SPRITE_LEVEL;
         else if (pick == 6)         fn = FUNCTION_WAIT_VSYNC;
         else if (pick == 7)         fn = 5'($urandom_range(3, 5));
         else                        fn = 5'($urandom_range(0, 31));
         apply_stimulus($urandom_range(0, 9) < 6, fn, 5'($urandom_range(0, 31)),
                        10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                        5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0,
                        5'($urandom_range(0, 31)));
      end

      // Drain any pending wait, bounded.
      idle(5'd0);
      @(negedge clock);
      for (int i = 0; i < 50 && !cmd_ready; i++) begin
         apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd0);
         idle(5'd0);
         @(negedge clock);
      end
      check_output("lit_drain_ready", cmd_ready, 1);

      // Reset while waiting returns to ACCEPT without a commit.
      apply_stimulus(1'b1, FUNCTION_WAIT_VSYNC, 5'd0, 10'd0, 10'd0, 5'd0, 1'b0, 5'd0);
      idle(5'd0);
      @(negedge clock);
      check_output("lit_wait2_lo", cmd_ready, 0);
      #2 reset = 1'b0;
      #1;
      check_output("lit_rst_ready", cmd_ready, 1);
      check_output("lit_rst_frame", frame_count, 0);
      check_output("lit_rst_bg", background_x, 0);
      idle(5'd0);
      idle(5'd0);
      reset = 1'b1;
      idle(5'd0);
      @(negedge clock);
      check_output("lit_rel_ready", cmd_ready, 1);

      // 65536 back-to-back commits wrap the frame counter.
      apply_stimulus(1'b0, 5'd0, 5'd0, 10'd0, 10'd0, 5'd0, 1'b1, 5'd0);
      repeat (65535) @(posedge clock);
      @(negedge clock);
      check_output("lit_frame_max", frame_count, 16'hFFFF);
      @(posedge clock);
      #1 vsync_pulse = 1'b0;
      @(negedge clock);
      check_output("lit_frame_wrap", frame_count, 0);
      check_output("lit_final_ready", cmd_ready, 1);

      repeat (2) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_command_unit.md
Name: sprite_command_unit

Overview:
- Parametrised successor to the processor's single-sprite output registers: holds state for NUM_SPRITES sprite slots plus background scroll, driven by decoded graphics functions from the processor.
- All writes land in shadow registers and commit atomically to active registers on the vsync pulse (double buffering).
- FUNCTION_WAIT_VSYNC stalls the command stream until the next frame boundary.
- Sits between the processor decode stage and the background/sprite render modules.

Parameters:
- NUM_SPRITES, 32: number of sprite slots, 1 to 64.
- COORD_WIDTH, 10: width of x/y coordinates.
- SPRITE_ID_WIDTH, 5: width of the sprite image id.
- SLOT_WIDTH, $clog2(NUM_SPRITES) (min 1): width of slot indices.
- FRAME_COUNT_WIDTH, 16: width of the frame counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit accepts a command this cycle.
- cmd_function  in  5  function code (package constants).
- cmd_slot  in  SLOT_WIDTH  target sprite slot.
- cmd_x  in  COORD_WIDTH  x operand.
- cmd_y  in  COORD_WIDTH  y operand.
- cmd_sprite_id  in  SPRITE_ID_WIDTH  image id operand.
- vsync_pulse  in  1  one-cycle frame-boundary strobe.
- rd_slot  in  SLOT_WIDTH  render-side read index.
- rd_x  out  COORD_WIDTH  active x of rd_slot.
- rd_y  out  COORD_WIDTH  active y of rd_slot.
- rd_sprite_id  out  SPRITE_ID_WIDTH  active id of rd_slot.
- rd_enable  out  1  active enable of rd_slot.
- background_x  out  COORD_WIDTH  active background scroll x.
- background_y  out  COORD_WIDTH  active background scroll y.
- frame_count  out  FRAME_COUNT_WIDTH  committed-frame counter.
- cmd_error  out  1  one-cycle pulse on an unsupported code or out-of-range slot.

Behaviour:
- Reset (reset low, asynchronous):
  - All shadow and active slot fields go to 0, enable to 0.
  - background_x/y go to 0, frame_count to 0.
  - cmd_error goes to 0, rd_* outputs to 0.
  - The state machine goes to ACCEPT.
  - Reset asserted during WAIT returns to ACCEPT with no commit.
- Handshake: a transfer occurs on the edge where cmd_valid && cmd_ready; cmd_ready is combinational from the state only (high in ACCEPT, low in WAIT).
- FUNCTION_SPRITE_POS (00010): shadow[slot] <= {x, y, id, enable=1}.
- FUNCTION_SPRITE_LEVEL (00001): shadow background_x/y <= cmd_x/cmd_y; slot is ignored.
- FUNCTION_WAIT_VSYNC (00110): state moves ACCEPT->WAIT.
  - The WAIT->ACCEPT transition happens on the first vsync_pulse seen strictly after acceptance.
  - A vsync_pulse in the accept cycle itself does not release the wait.
  - cmd_ready is high again the cycle after the releasing pulse.
- Codes 00011, 00100, 00101 and any other code: accepted, no state change, cmd_error=1 for one cycle.
- SPRITE_POS with slot >= NUM_SPRITES (non-power-of-2 depth): no write, cmd_error=1.
- Commit: on every vsync_pulse, in any state, all active registers <= shadow values from before that edge, and frame_count increments.
  - frame_count wraps from all-ones to 0.
  - A write accepted on the same edge as the pulse updates the shadow only and becomes visible at the following vsync.
- Read port: rd_* are registered with 1-cycle latency from rd_slot against the active registers.
  - A commit edge and a read in the same cycle return pre-commit data.
  - An out-of-range rd_slot returns zeros.
- background_x/y are driven directly from the active registers (no extra latency).

Decomposition:
- Package sprite_command_pkg holds:
  - The FUNCTION_* 5-bit code constants, shared with the processor decode.
  - A state enum {ACCEPT, WAIT}.
  - A packed slot struct {x, y, id, enable}, width 2*COORD_WIDTH+SPRITE_ID_WIDTH+1.
- Sub-module sprite_slot_buffer: one shadow/active register pair with write-enable and commit inputs, instantiated NUM_SPRITES times via generate.
- Top level holds the FSM, the decode-to-write-enable logic, the background pair, frame_count and the read mux.

Test Plan:
- Reset released, vsync pulsed once -> rd_* at any slot all 0, frame_count=1, background 0/0.
- SPRITE_POS slot 3, x=100, y=50, id=7:
  - before vsync, rd_slot=3 -> x=0, enable=0;
  - after vsync + 1 cycle -> x=100, y=50, id=7, enable=1.
- SPRITE_LEVEL x=640, y=12 in the same cycle as a vsync pulse -> background stays 0/0; after the next vsync -> 640/12.
- WAIT_VSYNC accepted in the same cycle as a vsync pulse -> cmd_ready stays low; the next pulse 20 cycles later raises cmd_ready one cycle after it.
- Code 00101, then NUM_SPRITES=24 with SPRITE_POS slot 30 -> cmd_error pulses for one cycle each; no slot changes after vsync.
- Reset asserted while in WAIT, then 65536 vsync pulses -> cmd_ready high after reset release; frame_count wraps to 0.
